// File: rtl/fwrisc_prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
// FWRISC_PROG_LOADER_CHECKSUM_EN adds the CHECK/ERROR states.
package fwrisc_prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_DONE  = 3'd1,
    ST_FULL  = 3'd2
`ifdef FWRISC_PROG_LOADER_CHECKSUM_EN
    , ST_CHECK = 3'd3,
    ST_ERROR = 3'd4
`endif
  } prog_ld_state_e;

  // Wide enough for any word width; sliced to W at the use site.
  localparam logic [255:0] DEFAULT_END_MARKER = '1;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fwrisc_prog_loader_if.sv
// Byte-in / ITCM-write-out signal bundle of the program loader.
interface fwrisc_prog_loader_if #(
  parameter int WORD_BYTES = 4,
  parameter int DEPTH      = 4096
);
  import fwrisc_prog_loader_pkg::*;
  localparam int W      = 8 * WORD_BYTES;
  localparam int ADDR_W = addr_width(DEPTH);

  logic              restart_i;
  logic [7:0]        rx_data_i;
  logic              rx_valid_i;
  logic              rx_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [W-1:0]      mem_wdata_o;
  logic              loading_o;
  logic              done_o;
  logic              full_o;
  logic              err_o;
  logic [ADDR_W:0]   word_count_o;

  modport master (
    output restart_i, rx_data_i, rx_valid_i,
    input  rx_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
           loading_o, done_o, full_o, err_o, word_count_o
  );

  modport slave (
    input  restart_i, rx_data_i, rx_valid_i,
    output rx_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
           loading_o, done_o, full_o, err_o, word_count_o
  );
endinterface

// File: rtl/fwrisc_byte_assembler.sv
// Shifts bytes into a word; word/word_valid present the completed word
// combinationally in the cycle its final byte arrives.
module fwrisc_byte_assembler #(
  parameter int WORD_BYTES = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    byte_valid,
  input  logic [7:0]              byte_data,
  output logic [8*WORD_BYTES-1:0] word,
  output logic                    word_valid
);
  localparam int W     = 8 * WORD_BYTES;
  localparam int CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  logic [W-1:0]     shreg;
  logic [CNT_W-1:0] cnt;

  generate
    if (WORD_BYTES == 1) begin : g_one
      assign word = byte_data;
    end else if (MSB_FIRST) begin : g_msb
      assign word = {shreg[W-9:0], byte_data};
    end else begin : g_lsb
      assign word = {byte_data, shreg[W-1:8]};
    end
  endgenerate

  assign word_valid = byte_valid && (cnt == CNT_W'(WORD_BYTES - 1));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (byte_valid) begin
      shreg <= word;
      cnt   <= word_valid ? '0 : cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/fwrisc_prog_loader.sv
// UART program loader: assembles bytes into words and writes them to ITCM.
// FWRISC_PROG_LOADER_CHECKSUM_EN enables the checksum trailer check.
module fwrisc_prog_loader
  import fwrisc_prog_loader_pkg::*;
#(
  parameter int                    WORD_BYTES = 4,
  parameter int                    DEPTH      = 4096,
  parameter logic [8*WORD_BYTES-1:0] END_MARKER = DEFAULT_END_MARKER[8*WORD_BYTES-1:0],
  parameter bit                    MSB_FIRST  = 1'b1
) (
  input logic                 clock,
  input logic                 reset,
  fwrisc_prog_loader_if.slave bus
);
  localparam int W      = 8 * WORD_BYTES;
  localparam int ADDR_W = addr_width(DEPTH);

  prog_ld_state_e    state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt, addr, addr_nxt;
  logic [ADDR_W:0]   cnt, cnt_nxt;
  logic [W-1:0]      wdata, wdata_nxt, word;
  logic              we, we_nxt, active, accept, word_valid;
`ifdef FWRISC_PROG_LOADER_CHECKSUM_EN
  logic [W-1:0]      sum, sum_nxt;
  assign active = (state == ST_LOAD) || (state == ST_CHECK);
`else
  assign active = (state == ST_LOAD);
`endif

  // A restart in the same cycle as a byte drops that byte.
  assign accept = bus.rx_valid_i && !bus.restart_i && active;

  fwrisc_byte_assembler #(.WORD_BYTES(WORD_BYTES), .MSB_FIRST(MSB_FIRST)) u_asm (
    .clock      (clock),
    .reset      (reset),
    .clear      (bus.restart_i),
    .byte_valid (accept),
    .byte_data  (bus.rx_data_i),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    addr_nxt  = addr;
    wdata_nxt = wdata;
    we_nxt    = 1'b0;
`ifdef FWRISC_PROG_LOADER_CHECKSUM_EN
    sum_nxt   = sum;
`endif
    if (bus.restart_i) begin
      state_nxt = ST_LOAD;
      ptr_nxt   = '0;
      cnt_nxt   = '0;
      addr_nxt  = '0;
      wdata_nxt = '0;
`ifdef FWRISC_PROG_LOADER_CHECKSUM_EN
      sum_nxt   = '0;
`endif
    end else if (word_valid) begin
      case (state)
        ST_LOAD: begin
          if (word == END_MARKER) begin
`ifdef FWRISC_PROG_LOADER_CHECKSUM_EN
            state_nxt = ST_CHECK;
`else
            state_nxt = ST_DONE;
`endif
          end else begin
            we_nxt    = 1'b1;
            addr_nxt  = ptr;
            wdata_nxt = word;
            ptr_nxt   = ptr + ADDR_W'(1);
            cnt_nxt   = cnt + (ADDR_W+1)'(1);
`ifdef FWRISC_PROG_LOADER_CHECKSUM_EN
            sum_nxt   = sum + word;
`endif
            if (ptr == ADDR_W'(DEPTH - 1)) state_nxt = ST_FULL;
          end
        end
`ifdef FWRISC_PROG_LOADER_CHECKSUM_EN
        ST_CHECK: state_nxt = (word == sum) ? ST_DONE : ST_ERROR;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_LOAD;
      ptr   <= '0;
      cnt   <= '0;
      addr  <= '0;
      wdata <= '0;
      we    <= 1'b0;
`ifdef FWRISC_PROG_LOADER_CHECKSUM_EN
      sum   <= '0;
`endif
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      addr  <= addr_nxt;
      wdata <= wdata_nxt;
      we    <= we_nxt;
`ifdef FWRISC_PROG_LOADER_CHECKSUM_EN
      sum   <= sum_nxt;
`endif
    end
  end

  assign bus.rx_en_o      = active;
  assign bus.loading_o    = active;
  assign bus.done_o       = !active;
  assign bus.full_o       = (state == ST_FULL);
`ifdef FWRISC_PROG_LOADER_CHECKSUM_EN
  assign bus.err_o        = (state == ST_ERROR);
`else
  assign bus.err_o        = 1'b0;
`endif
  assign bus.mem_we_o     = we;
  assign bus.mem_addr_o   = addr;
  assign bus.mem_wdata_o  = wdata;
  assign bus.word_count_o = cnt;
endmodule

// File: tb/tb_fwrisc_prog_loader.sv
// Bench: two loaders (4096 deep MSB-first, 4 deep LSB-first) on one random
// byte stream, each checked every cycle against a byte-list reference model.
module tb_fwrisc_prog_loader;
`ifdef FWRISC_PROG_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  localparam int MODE_LOAD = 0, MODE_CHECK = 1, MODE_DONE = 2, MODE_FULL = 3, MODE_ERR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s = 1'b1, restart_s = 1'b0, valid_s = 1'b0;
  logic [7:0] data_s = 8'h00;

  fwrisc_prog_loader_if #(.WORD_BYTES(4), .DEPTH(4096)) if0();
  fwrisc_prog_loader_if #(.WORD_BYTES(4), .DEPTH(4))    if1();
  assign if0.restart_i = restart_s;  assign if1.restart_i = restart_s;
  assign if0.rx_data_i = data_s;     assign if1.rx_data_i = data_s;
  assign if0.rx_valid_i = valid_s;   assign if1.rx_valid_i = valid_s;

  fwrisc_prog_loader #(.WORD_BYTES(4), .DEPTH(4096), .MSB_FIRST(1'b1)) dut0 (
    .clock(clk), .reset(rst_s), .bus(if0));
  fwrisc_prog_loader #(.WORD_BYTES(4), .DEPTH(4), .MSB_FIRST(1'b0)) dut1 (
    .clock(clk), .reset(rst_s), .bus(if1));

  int n_cmp = 0, n_fail = 0;
  int depth_of [2] = '{4096, 4};
  bit msb_of   [2] = '{1'b1, 1'b0};

  // reference model state
  int          mode [2];
  logic [7:0]  mb   [2][4];
  int          nb   [2];
  int          ptr  [2];
  int          cnt  [2];
  logic [31:0] sum  [2];
  bit          ewe  [2];
  int          eaddr[2];
  logic [31:0] ewd  [2];

  // observed writes, used by the directed literal checks
  int          nwr  [2];
  int          cap_addr[2];
  logic [31:0] cap_data[2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int d, input bit r, input bit rs, input bit v, input logic [7:0] b);
    logic [31:0] w;
    ewe[d] = 1'b0;
    if (r || rs) begin
      mode[d] = MODE_LOAD; nb[d] = 0; ptr[d] = 0; cnt[d] = 0; sum[d] = '0;
      return;
    end
    if (!(v && (mode[d] == MODE_LOAD || mode[d] == MODE_CHECK))) return;
    mb[d][nb[d]] = b;
    nb[d]++;
    if (nb[d] < 4) return;
    nb[d] = 0;
    w = '0;
    for (int i = 0; i < 4; i++)
      if (msb_of[d]) w = (w << 8) | 32'(mb[d][i]);
      else           w = w | (32'(mb[d][i]) << (8 * i));
    if (mode[d] == MODE_CHECK) mode[d] = (w == sum[d]) ? MODE_DONE : MODE_ERR;
    else if (w == 32'hFFFF_FFFF) mode[d] = CK ? MODE_CHECK : MODE_DONE;
    else begin
      ewe[d] = 1'b1; eaddr[d] = ptr[d]; ewd[d] = w;
      sum[d] = sum[d] + w; cnt[d]++;
      if (ptr[d] == depth_of[d] - 1) mode[d] = MODE_FULL;
      ptr[d]++;
    end
  endtask

  task automatic compare(input int d);
    logic act_we, act_en, act_ld, act_dn, act_fl, act_er;
    logic [31:0] act_addr, act_wd, act_wc;
    bit ld;
    string s;
    if (d == 0) begin
      act_we = if0.mem_we_o; act_en = if0.rx_en_o; act_ld = if0.loading_o; act_dn = if0.done_o;
      act_fl = if0.full_o; act_er = if0.err_o; act_addr = 32'(if0.mem_addr_o);
      act_wd = if0.mem_wdata_o; act_wc = 32'(if0.word_count_o);
    end else begin
      act_we = if1.mem_we_o; act_en = if1.rx_en_o; act_ld = if1.loading_o; act_dn = if1.done_o;
      act_fl = if1.full_o; act_er = if1.err_o; act_addr = 32'(if1.mem_addr_o);
      act_wd = if1.mem_wdata_o; act_wc = 32'(if1.word_count_o);
    end
    s  = $sformatf("dut%0d", d);
    ld = (mode[d] == MODE_LOAD || mode[d] == MODE_CHECK);
    chk({s, " mem_we"},     64'(act_we), 64'(ewe[d]));
    chk({s, " rx_en"},      64'(act_en), 64'(ld));
    chk({s, " loading"},    64'(act_ld), 64'(ld));
    chk({s, " done"},       64'(act_dn), 64'(!ld));
    chk({s, " full"},       64'(act_fl), 64'(mode[d] == MODE_FULL));
    chk({s, " err"},        64'(act_er), 64'(mode[d] == MODE_ERR));
    chk({s, " word_count"}, 64'(act_wc), 64'(cnt[d]));
    if (ewe[d]) begin
      chk({s, " mem_addr"},  64'(act_addr), 64'(eaddr[d]));
      chk({s, " mem_wdata"}, 64'(act_wd),   64'(ewd[d]));
    end
    if (act_we === 1'b1) begin
      nwr[d]++; cap_addr[d] = int'(act_addr); cap_data[d] = act_wd;
    end
  endtask

  // Inputs change 1 time unit after the falling edge, so here they still
  // hold the values the DUT sampled at the preceding rising edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      model_step(d, rst_s, restart_s, valid_s, data_s);
      compare(d);
    end
  end

  task automatic cyc(input bit v, input logic [7:0] b, input bit rs);
    @(negedge clk); #1;
    valid_s = v; data_s = b; restart_s = rs;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, t[31:24], 1'b0);
      t = t << 8;
      if (max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
    end
  endtask

  task automatic do_restart();
    cyc(1'b0, 8'h00, 1'b1);
    idle(1);
    nwr[0] = 0; nwr[1] = 0;
  endtask

  task automatic close_load(input logic [31:0] trailer);
    send_word(32'hFFFF_FFFF, 1);
    if (CK) send_word(trailer, 1);
    idle(2);
  endtask

  initial begin
    nwr[0] = 0; nwr[1] = 0;
    idle(3);
    chk("reset rx_en",      64'(if0.rx_en_o), 64'd1);
    chk("reset loading",    64'(if0.loading_o), 64'd1);
    chk("reset done",       64'(if0.done_o), 64'd0);
    chk("reset word_count", 64'(if0.word_count_o), 64'd0);
    rst_s = 1'b0;
    idle(2);

    // basic load in both byte orders
    send_word(32'h1122_3344, 0);
    close_load(32'h1122_3344);
    chk("msb wdata",   64'(cap_data[0]), 64'h1122_3344);
    chk("msb addr",    64'(cap_addr[0]), 64'd0);
    chk("msb nwrites", 64'(nwr[0]), 64'd1);
    chk("lsb wdata",   64'(cap_data[1]), 64'h4433_2211);
    chk("done",        64'(if0.done_o), 64'd1);
    chk("rx_en off",   64'(if0.rx_en_o), 64'd0);
    chk("count 1",     64'(if0.word_count_o), 64'd1);
    chk("err clear",   64'(if0.err_o), 64'd0);

    // restart visibility one cycle later
    cyc(1'b0, 8'h00, 1'b1);
    idle(1);
    nwr[0] = 0; nwr[1] = 0;
    chk("restart rx_en", 64'(if0.rx_en_o), 64'd1);
    chk("restart done",  64'(if0.done_o), 64'd0);
    chk("restart count", 64'(if0.word_count_o), 64'd0);

    // fill the 4-deep instance, then keep sending
    for (int i = 0; i < 6; i++) begin
      logic [31:0] w;
      w = $urandom;
      if (w == 32'hFFFF_FFFF) w = 32'h0;
      send_word(w, 2);
    end
    idle(2);
    chk("full flag",    64'(if1.full_o), 64'd1);
    chk("full nwrites", 64'(nwr[1]), 64'd4);
    chk("full addr",    64'(cap_addr[1]), 64'd3);
    chk("deep count",   64'(if0.word_count_o), 64'd6);

    // partial word discarded by restart
    do_restart();
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'(i + 1), 1'b0);
    do_restart();
    send_word(32'hAABB_CCDD, 1);
    idle(2);
    chk("rst-partial wdata", 64'(cap_data[0]), 64'hAABB_CCDD);
    chk("rst-partial addr",  64'(cap_addr[0]), 64'd0);
    chk("rst-partial count", 64'(if0.word_count_o), 64'd1);

    // restart coincident with the final byte
    do_restart();
    cyc(1'b1, 8'h01, 1'b0); cyc(1'b1, 8'h02, 1'b0); cyc(1'b1, 8'h03, 1'b0);
    cyc(1'b1, 8'h04, 1'b1);
    idle(2);
    nwr[0] = 0;
    idle(1);
    chk("coincident count",   64'(if0.word_count_o), 64'd0);
    send_word(32'h0506_0708, 0);
    idle(2);
    chk("coincident addr",    64'(cap_addr[0]), 64'd0);
    chk("coincident wdata",   64'(cap_data[0]), 64'h0506_0708);

    // checksum trailer: 1 + 2 = 3 matches, 4 does not
    do_restart();
    send_word(32'd1, 1); send_word(32'd2, 1);
    close_load(32'd3);
    chk("sum ok done", 64'(if0.done_o), 64'd1);
    chk("sum ok err",  64'(if0.err_o), 64'd0);
    chk("sum count",   64'(if0.word_count_o), 64'd2);
    do_restart();
    send_word(32'd1, 1); send_word(32'd2, 1);
    close_load(32'd4);
    chk("sum bad err",  64'(if0.err_o), 64'(CK));
    chk("sum bad done", 64'(if0.done_o), 64'd1);

    // random traffic; the per-cycle compare does the checking
    do_restart();
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(99, 0));
      if (r < 2)       cyc(1'b1, 8'($urandom), 1'b1);
      else if (r < 4)  cyc(1'b0, 8'h00, 1'b1);
      else if (r < 60) cyc(1'b1, ($urandom_range(3, 0) == 0) ? 8'hFF : 8'($urandom), 1'b0);
      else             cyc(1'b0, 8'h00, 1'b0);
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
